// File: rtl/pipeline_pkg.sv
// Shared defaults, tag type and the round-robin pick helper for the
// pipeline-to-resource arbiter slice.
package pipeline_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] tag_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= 8).
  // Returns {found, index}.
  function automatic logic [3:0] rr_first(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input int n);
    logic found;
    int   idx;
    rr_first = '0;
    found    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        found    = 1'b1;
        rr_first = {1'b1, idx[2:0]};
      end
    end
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags; remembers who owns each outstanding beat.
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_tag,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/shared_resource_arbiter.sv
// Round-robin share of one resource port among NUM_REQ pipeline fronts, with
// responses routed back in issue order via a tag FIFO.
module shared_resource_arbiter
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_flush,
  output logic [NUM_REQ-1:0]             req_stall,
  output logic [DATA_W-1:0]              res_data,
  output logic                           res_valid,
  output logic                           res_flush,
  input  logic                           res_stall,
  input  logic [DATA_W-1:0]              rsp_data_in,
  input  logic                           rsp_valid_in,
  input  logic                           rsp_flush_in,
  output logic                           rsp_stall_out,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_flush,
  input  logic [NUM_REQ-1:0]             rsp_stall,
  output logic [$clog2(TAG_DEPTH):0]     outstanding,
  output logic                           err_orphan
);
  localparam int TW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [TW-1:0]      rr_ptr, grant_idx, issue_tag, tag_head;
  logic [3:0]         pick;
  logic [NUM_REQ-1:0] grant;
  logic               issue_free, push, can_grant, grant_vld;
  logic               fifo_full, fifo_empty, pop, rsp_free;

  // Issue side: a grant must leave room for the beat leaving the register now.
  assign issue_free = ~res_valid | ~res_stall;
  assign push       = res_valid & ~res_stall;
  assign can_grant  = issue_free && !fifo_full &&
                      (({1'b0, outstanding} + (CW+1)'(push)) < (CW+1)'(TAG_DEPTH));
  assign pick       = rr_first(8'(req_valid), 3'(rr_ptr), NUM_REQ);
  assign grant_vld  = can_grant & pick[3];
  assign grant_idx  = TW'(pick[2:0]);
  assign grant      = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_stall  = ~grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flush <= 1'b0;
      issue_tag <= '0;
      rr_ptr    <= '0;
    end else begin
      if (issue_free) begin
        res_valid <= grant_vld;
        if (grant_vld) begin
          res_data  <= req_data[grant_idx];
          res_flush <= req_flush[grant_idx];
          issue_tag <= grant_idx;
        end
      end
      if (grant_vld)
        rr_ptr <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
    end
  end

  tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tags (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (issue_tag),
    .pop      (pop),
    .head     (tag_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

  // Response side: with no tags outstanding, never stall so orphans drain.
  assign rsp_free      = ~|(rsp_valid & rsp_stall);
  assign rsp_stall_out = ~fifo_empty & ~rsp_free;
  assign pop           = rsp_valid_in & ~rsp_stall_out & ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_flush  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (rsp_free) begin
        rsp_valid <= pop ? (NUM_REQ'(1) << tag_head) : '0;
        if (pop) begin
          rsp_data  <= rsp_data_in;
          rsp_flush <= rsp_flush_in;
        end
      end
      if (rsp_valid_in && fifo_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter: reset, single beat, round-robin,
// back-pressure, tag FIFO full, response stall, orphan and mid-traffic reset.
module tb_shared_resource_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_valid, req_flush, req_stall;
  logic [31:0]      res_data;
  logic             res_valid, res_flush, res_stall;
  logic [31:0]      rsp_data_in;
  logic             rsp_valid_in, rsp_flush_in, rsp_stall_out;
  logic [31:0]      rsp_data;
  logic [3:0]       rsp_valid, rsp_stall;
  logic             rsp_flush;
  logic [3:0]       outstanding;
  logic             err_orphan;

  int n_cmp = 0;
  int n_err = 0;

  shared_resource_arbiter #(.NUM_REQ(4), .DATA_W(32), .TAG_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_flush(req_flush), .req_stall(req_stall),
    .res_data(res_data), .res_valid(res_valid), .res_flush(res_flush), .res_stall(res_stall),
    .rsp_data_in(rsp_data_in), .rsp_valid_in(rsp_valid_in), .rsp_flush_in(rsp_flush_in),
    .rsp_stall_out(rsp_stall_out),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_flush(rsp_flush), .rsp_stall(rsp_stall),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    req_data = '0; req_valid = '0; req_flush = '0; res_stall = 1'b0;
    rsp_data_in = '0; rsp_valid_in = 1'b0; rsp_flush_in = 1'b0; rsp_stall = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %0h want 0", res_valid); end
    n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_res_data got %0h want 0", res_data); end
    n_cmp++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
    n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err_orphan got %0h want 0", err_orphan); end
    n_cmp++; if (req_stall !== 4'hF) begin n_err++; $display("FAIL reset_req_stall got %0h want f", req_stall); end
    reset = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0100; req_data[2] = 32'hA5A5_0001; req_flush[2] = 1'b1;
    #1;
    n_cmp++; if (req_stall !== 4'b1011) begin n_err++; $display("FAIL single_req_stall got %0h want b", req_stall); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_res_valid got %0h want 1", res_valid); end
    n_cmp++; if (res_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_res_data got %0h want a5a50001", res_data); end
    n_cmp++; if (res_flush !== 1'b1) begin n_err++; $display("FAIL single_res_flush got %0h want 1", res_flush); end
    req_valid = '0; req_flush = '0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_res_drain got %0h want 0", res_valid); end
    n_cmp++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
    repeat (2) @(negedge clk);
    rsp_valid_in = 1'b1; rsp_data_in = 32'hA5A5_0001; rsp_flush_in = 1'b1;
    #1;
    n_cmp++; if (rsp_stall_out !== 1'b0) begin n_err++; $display("FAIL single_rsp_stall_out got %0h want 0", rsp_stall_out); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL single_rsp_valid got %0h want 4", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_rsp_data got %0h want a5a50001", rsp_data); end
    n_cmp++; if (rsp_flush !== 1'b1) begin n_err++; $display("FAIL single_rsp_flush got %0h want 1", rsp_flush); end
    n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL single_pop got %0d want 0", outstanding); end
    rsp_valid_in = 1'b0; rsp_flush_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_rsp_clear got %0h want 0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_stall;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'h100 + i;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_stall = ~(4'b0001 << (k % 4));
      #1;
      n_cmp++; if (req_stall !== exp_stall) begin n_err++; $display("FAIL rr_stall[%0d] got %0h want %0h", k, req_stall, exp_stall); end
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b1 || res_data !== 32'h100 + 32'(k % 4)) begin
        n_err++; $display("FAIL rr_beat[%0d] got v=%0h d=%0h want v=1 d=%0h", k, res_valid, res_data, 32'h100 + 32'(k % 4));
      end
    end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (outstanding !== 4'd6) begin n_err++; $display("FAIL rr_outstanding got %0d want 6", outstanding); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    req_data[0] = 32'hD0; req_data[1] = 32'hD1; req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++; if (res_data !== 32'hD0) begin n_err++; $display("FAIL bp_first got %0h want d0", res_data); end
    res_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (req_stall !== 4'hF) begin n_err++; $display("FAIL bp_stall[%0d] got %0h want f", k, req_stall); end
      @(negedge clk);
      n_cmp++; if (res_data !== 32'hD0 || res_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%0h d=%0h want v=1 d=d0", k, res_valid, res_data);
      end
    end
    res_stall = 1'b0;
    #1;
    n_cmp++; if (req_stall !== 4'b1101) begin n_err++; $display("FAIL bp_resume_stall got %0h want d", req_stall); end
    @(negedge clk);
    n_cmp++; if (res_data !== 32'hD1) begin n_err++; $display("FAIL bp_resume1 got %0h want d1", res_data); end
    #1;
    n_cmp++; if (req_stall !== 4'b1110) begin n_err++; $display("FAIL bp_wrap_stall got %0h want e", req_stall); end
    @(negedge clk);
    n_cmp++; if (res_data !== 32'hD0) begin n_err++; $display("FAIL bp_resume2 got %0h want d0", res_data); end
    n_cmp++; if (outstanding !== 4'd2) begin n_err++; $display("FAIL bp_outstanding got %0d want 2", outstanding); end
    req_valid = '0;
  endtask

  task automatic test_fifo_full;
    int grants;
    do_reset();
    grants = 0;
    req_data[0] = 32'hF0; req_valid = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!req_stall[0]) grants++;
      @(negedge clk);
    end
    n_cmp++; if (grants !== 8) begin n_err++; $display("FAIL full_grants got %0d want 8", grants); end
    n_cmp++; if (outstanding !== 4'd8) begin n_err++; $display("FAIL full_outstanding got %0d want 8", outstanding); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL full_res_valid got %0h want 0", res_valid); end
    rsp_valid_in = 1'b1; rsp_data_in = 32'h55;
    #1;
    n_cmp++; if (req_stall !== 4'hF) begin n_err++; $display("FAIL full_req_stall got %0h want f", req_stall); end
    n_cmp++; if (rsp_stall_out !== 1'b0) begin n_err++; $display("FAIL full_rsp_stall_out got %0h want 0", rsp_stall_out); end
    @(negedge clk);
    rsp_valid_in = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL full_rsp_valid got %0h want 1", rsp_valid); end
    n_cmp++; if (outstanding !== 4'd7) begin n_err++; $display("FAIL full_pop got %0d want 7", outstanding); end
    #1;
    n_cmp++; if (req_stall !== 4'b1110) begin n_err++; $display("FAIL full_regrant got %0h want e", req_stall); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_rsp_stall;
    do_reset();
    req_data[1] = 32'h11; req_data[2] = 32'h22; req_valid = 4'b0110;
    @(negedge clk);
    n_cmp++; if (res_data !== 32'h11) begin n_err++; $display("FAIL rs_issue1 got %0h want 11", res_data); end
    @(negedge clk);
    n_cmp++; if (res_data !== 32'h22) begin n_err++; $display("FAIL rs_issue2 got %0h want 22", res_data); end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (outstanding !== 4'd2) begin n_err++; $display("FAIL rs_outstanding got %0d want 2", outstanding); end
    rsp_stall = 4'b0010; rsp_valid_in = 1'b1; rsp_data_in = 32'hAA;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'hAA) begin
      n_err++; $display("FAIL rs_first got v=%0h d=%0h want v=2 d=aa", rsp_valid, rsp_data);
    end
    rsp_data_in = 32'hBB;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (rsp_stall_out !== 1'b1) begin n_err++; $display("FAIL rs_stall_out[%0d] got %0h want 1", k, rsp_stall_out); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'hAA || outstanding !== 4'd1) begin
        n_err++; $display("FAIL rs_hold[%0d] got v=%0h d=%0h o=%0d want v=2 d=aa o=1", k, rsp_valid, rsp_data, outstanding);
      end
    end
    rsp_stall = '0;
    #1;
    n_cmp++; if (rsp_stall_out !== 1'b0) begin n_err++; $display("FAIL rs_release got %0h want 0", rsp_stall_out); end
    @(negedge clk);
    rsp_valid_in = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data !== 32'hBB || outstanding !== 4'd0) begin
      n_err++; $display("FAIL rs_second got v=%0h d=%0h o=%0d want v=4 d=bb o=0", rsp_valid, rsp_data, outstanding);
    end
  endtask

  task automatic test_orphan_reset;
    do_reset();
    rsp_valid_in = 1'b1; rsp_data_in = 32'hEE;
    #1;
    n_cmp++; if (rsp_stall_out !== 1'b0) begin n_err++; $display("FAIL orphan_stall_out got %0h want 0", rsp_stall_out); end
    @(negedge clk);
    rsp_valid_in = 1'b0;
    n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_flag got %0h want 1", err_orphan); end
    n_cmp++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL orphan_dropped got %0h want 0", rsp_valid); end
    for (int i = 0; i < 4; i++) req_data[i] = 32'hC0 + i;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    n_cmp++; if (err_orphan !== 1'b1 || res_valid !== 1'b1 || outstanding !== 4'd1) begin
      n_err++; $display("FAIL orphan_sticky got e=%0h v=%0h o=%0d want e=1 v=1 o=1", err_orphan, res_valid, outstanding);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_flush !== 1'b0) begin
      n_err++; $display("FAIL midreset_res got v=%0h d=%0h want 0", res_valid, res_data);
    end
    n_cmp++; if (rsp_valid !== 4'h0 || rsp_data !== 32'h0 || outstanding !== 4'd0 || err_orphan !== 1'b0) begin
      n_err++; $display("FAIL midreset_rsp got v=%0h d=%0h o=%0d e=%0h want 0", rsp_valid, rsp_data, outstanding, err_orphan);
    end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_fifo_full();
    test_rsp_stall();
    test_orphan_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shared_resource_arbiter.md
# shared_resource_arbiter

Round-robin arbiter that shares one shared resource among NUM_REQ pipeline fronts. It sits between the stage-3 outputs of NUM_REQ pipelines and the single resource port. It registers each granted beat toward the resource and records the grant index in an in-order tag FIFO. It routes each resource response back to the requester that issued it, using valid/stall/flush semantics identical to the pipeline stages.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, beat data width
- TAG_DEPTH, 8, outstanding-request FIFO depth (power of two)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0), released synchronously by the upstream reset generator
- req_data  in  NUM_REQ*DATA_W  requester beats; slice i = [i*DATA_W +: DATA_W]
- req_valid  in  NUM_REQ  beat present from requester i
- req_flush  in  NUM_REQ  flush sideband travelling with beat i
- req_stall  out  NUM_REQ  back-pressure to requester i (combinational)
- res_data  out  DATA_W  registered beat to resource
- res_valid  out  1  registered valid to resource
- res_flush  out  1  registered flush to resource
- res_stall  in  1  resource cannot accept res_* this cycle
- rsp_data_in  in  DATA_W  response beat from resource
- rsp_valid_in  in  1  response valid
- rsp_flush_in  in  1  response flush sideband
- rsp_stall_out  out  1  back-pressure to resource response path (combinational)
- rsp_data  out  DATA_W  registered response data, broadcast to all requesters
- rsp_valid  out  NUM_REQ  registered one-hot response valid
- rsp_flush  out  1  registered response flush
- rsp_stall  in  NUM_REQ  consumer-side stall per requester
- outstanding  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
- err_orphan  out  1  sticky: response arrived with empty tag FIFO

## Operation
- Transfer rule everywhere: a beat moves when valid=1 and stall=0 in the same cycle.
- Issue register (res_*) is free when res_valid=0 or res_stall=0.
- Arbitration: when the issue register is free and the FIFO is not full (counting the push this cycle), grant the first req_valid[i] at or after rr_ptr, wrapping modulo NUM_REQ. After a grant, rr_ptr = grant+1 mod NUM_REQ. Without a grant, rr_ptr holds.
- req_stall[i] = ~grant[i]. Non-requesting requesters also see stall=1 unless granted.
- Granted beat loads the issue register: data, flush, valid=1, and issue_tag=i. If the register drains with no new grant, valid clears.
- Tag push: when res_valid & ~res_stall, issue_tag is pushed to the FIFO.
- Response path: response register (rsp_*) is free when no rsp_valid bit is set or the stall of the owning requester is 0.
- rsp_stall_out = ~(response register free) when the FIFO is non-empty. It is 0 when the FIFO is empty, so orphans are drained.
- An accepted response pops the head tag k, loads rsp_data/rsp_flush, and sets rsp_valid = one-hot(k).
- Orphan response (FIFO empty, rsp_valid_in=1): dropped, err_orphan set until reset.
- Simultaneous push and pop: occupancy is unchanged, and head and tail pointers both advance.
- Flush is payload only. The arbiter never discards beats on flush.
- Reset: res_valid=0, res_data=0, res_flush=0, rsp_valid=0, rsp_data=0, rsp_flush=0, rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0. Reset mid-transaction discards all in-flight beats and tags.

## Timing
- Grant in cycle t -> res_valid=1 at t+1.
- Resource accept at t -> tag visible at the FIFO head by t+1.
- Response accepted at t -> rsp_valid one-hot at t+1.
- Full throughput: one grant per cycle while res_stall=0 and the FIFO is not full.
- FIFO full: no grants, all req_stall=1, until a pop.
- req_stall and rsp_stall_out are combinational from inputs and state. No combinational path exists from res_stall to res_valid.

## Structure
- Shared package pipeline_pkg holds: DATA_W default, NUM_REQ default, a tag type sized $clog2(NUM_REQ), and a round-robin helper function (first set bit at or after a pointer).
- One sub-module, tag_fifo: synchronous FIFO of tags with push/pop/full/empty/count and the same async active-low reset.

## Test plan
- Single requester: req_valid[2]=1, data 0xA5A5_0001, resource echoes the beat 3 cycles later. Expect res_valid at t+1, rsp_valid=4'b0100 and rsp_data=0xA5A5_0001 at response+1.
- Round-robin: all four req_valid=1 continuously, res_stall=0. Expect grant order 0,1,2,3,0,… and res_valid every cycle.
- Back-pressure: hold res_stall=1 for 5 cycles with two requesters valid. Expect res_data stable, no grants, and then resumed order without loss or duplication.
- FIFO full: TAG_DEPTH=8, resource accepts 8 beats and returns none. Expect outstanding=8 and all req_stall=1. The first response then lets a grant occur in the next cycle.
- Response stall: rsp_stall[1]=1 while the head tag is 1. Expect rsp_stall_out=1 and rsp_* held. Releasing rsp_stall[1] delivers the beat and then the next one.
- Orphan and reset: rsp_valid_in=1 with an empty FIFO. Expect err_orphan=1 and the response dropped. Reset=0 mid-traffic clears all outputs to zero.
